// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU / UART debug) arbiter for the single-port SAP-2 system RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the CPU wins ties.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  gnt_dbg
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                state, state_next;
  logic                  grant;
  logic                  win_dbg;
  logic                  tie_dbg;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, dbg_rdata_q;
  logic                  done_rd;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = debug owned the last grant; starts as debug so the CPU wins the first tie.
  logic last_owner;

  always_ff @(posedge clk) begin
    if (reset)      last_owner <= 1'b1;
    else if (grant) last_owner <= win_dbg;
  end

  assign tie_dbg = ~last_owner;
`else
  assign tie_dbg = 1'b0;
`endif

  assign win_dbg = dbg_req & (~cpu_req | tie_dbg);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    unique case (state)
      IDLE: if (cpu_req || dbg_req) begin
        grant      = 1'b1;
        state_next = ISSUE;
      end
      ISSUE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      gnt_dbg   <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        gnt_dbg   <= win_dbg;
        lat_we    <= win_dbg ? dbg_we    : cpu_we;
        lat_addr  <= win_dbg ? dbg_addr  : cpu_addr;
        lat_wdata <= win_dbg ? dbg_wdata : cpu_wdata;
      end
    end
  end

  // Read data is captured on DONE of a read so it holds until the next read ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else if (done_rd) begin
      if (gnt_dbg) dbg_rdata_q <= ram_rdata;
      else         cpu_rdata_q <= ram_rdata;
    end
  end

  assign done_rd   = (state == DONE) && !lat_we;
  assign ram_we    = (state == ISSUE) && lat_we && !reset;
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;
  assign busy      = (state != IDLE);
  assign cpu_ack   = (state == DONE) && !gnt_dbg && !reset;
  assign dbg_ack   = (state == DONE) &&  gnt_dbg && !reset;
  assign cpu_rdata = (done_rd && !gnt_dbg) ? ram_rdata : cpu_rdata_q;
  assign dbg_rdata = (done_rd &&  gnt_dbg) ? ram_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with a small one-cycle-latency RAM model.
// Build with ARB_ROUND_ROBIN_EN defined to check the round-robin grant order.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       dbg_req, dbg_we, dbg_ack;
  logic [15:0] dbg_addr;
  logic [7:0] dbg_wdata, dbg_rdata;
  logic       ram_we;
  logic [15:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic       busy, gnt_dbg;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  logic       got_cpu, got_dbg;
  logic [3:0] exp_order;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .gnt_dbg(gnt_dbg)
  );

  // Synchronous RAM: read-old, data valid one cycle after the address.
  always @(posedge clk) begin
    ram_rdata = mem[ram_addr[7:0]];
    if (ram_we) mem[ram_addr[7:0]] = ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits (bounded) for the next ack of either port.
  task automatic wait_ack(output logic c, output logic d);
    logic timed_out;
    timed_out = 1'b1;
    c = 1'b0;
    d = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cpu_ack || dbg_ack) begin
        c = cpu_ack;
        d = dbg_ack;
        timed_out = 1'b0;
        break;
      end
    end
    check("ack_timeout", 32'(timed_out), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h3C;
    mem[8'h30] = 8'h77;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick();

    // Reset state
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cpu_ack",   32'(cpu_ack),   32'd0);
    check("rst_dbg_ack",   32'(dbg_ack),   32'd0);
    check("rst_ram_we",    32'(ram_we),    32'd0);
    check("rst_ram_addr",  32'(ram_addr),  32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
    check("rst_gnt_dbg",   32'(gnt_dbg),   32'd0);
    reset = 1'b0;
    tick();

    // CPU write 0x0010 <= 0xA5
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
    tick();
    check("wr_issue_ram_we",    32'(ram_we),    32'd1);
    check("wr_issue_ram_addr",  32'(ram_addr),  32'h10);
    check("wr_issue_ram_wdata", 32'(ram_wdata), 32'hA5);
    check("wr_issue_busy",      32'(busy),      32'd1);
    check("wr_issue_cpu_ack",   32'(cpu_ack),   32'd0);
    tick();
    check("wr_done_ram_we",  32'(ram_we),  32'd0);
    check("wr_done_cpu_ack", 32'(cpu_ack), 32'd1);
    check("wr_done_busy",    32'(busy),    32'd1);
    cpu_req = 0;
    tick();
    check("wr_after_cpu_ack", 32'(cpu_ack),   32'd0);
    check("wr_after_busy",    32'(busy),      32'd0);
    check("wr_mem_10",        32'(mem[8'h10]), 32'hA5);

    // CPU read 0x0010, dropping req during ISSUE
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick();
    check("rd_issue_ram_we", 32'(ram_we), 32'd0);
    cpu_req = 0;
    tick();
    check("rd_done_cpu_ack",   32'(cpu_ack),   32'd1);
    check("rd_done_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    tick();
    check("rd_hold_cpu_ack",   32'(cpu_ack),   32'd0);
    check("rd_hold_cpu_rdata", 32'(cpu_rdata), 32'hA5);

    // Debug read 0x0020 (preloaded 0x3C)
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0020;
    tick();
    check("dbg_issue_dbg_ack", 32'(dbg_ack), 32'd0);
    check("dbg_issue_cpu_ack", 32'(cpu_ack), 32'd0);
    tick();
    check("dbg_done_dbg_ack",   32'(dbg_ack),   32'd1);
    check("dbg_done_dbg_rdata", 32'(dbg_rdata), 32'h3C);
    check("dbg_done_cpu_ack",   32'(cpu_ack),   32'd0);
    check("dbg_done_gnt_dbg",   32'(gnt_dbg),   32'd1);
    dbg_req = 0;
    tick();
    check("dbg_hold_dbg_rdata", 32'(dbg_rdata), 32'h3C);

    // Both requesting continuously for 4 transactions
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b0000;
`endif
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      wait_ack(got_cpu, got_dbg);
      check("tie_single_ack", 32'(got_cpu ^ got_dbg), 32'd1);
      check("tie_owner",      32'(got_dbg),           32'(exp_order[i]));
      check("tie_gnt_dbg",    32'(gnt_dbg),           32'(exp_order[i]));
      if (got_dbg) check("tie_dbg_rdata", 32'(dbg_rdata), 32'h3C);
      else         check("tie_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    end
    cpu_req = 0;
    wait_ack(got_cpu, got_dbg);
    check("drop_cpu_dbg_ack", 32'(got_dbg), 32'd1);
    check("drop_cpu_cpu_ack", 32'(got_cpu), 32'd0);
    dbg_req = 0;
    tick();

    // Address change during ISSUE is ignored
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick();
    check("chg_issue_ram_addr", 32'(ram_addr), 32'h10);
    cpu_addr = 16'h0030;
    tick();
    check("chg_done_ram_addr",  32'(ram_addr),  32'h10);
    check("chg_done_cpu_ack",   32'(cpu_ack),   32'd1);
    check("chg_done_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    cpu_req = 0;
    tick();

    // Reset during ISSUE of a write 0x0040 <= 0xFF
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 8'hFF;
    tick();
    check("rstw_issue_ram_we", 32'(ram_we), 32'd1);
    reset = 1; cpu_req = 0;
    #1;
    check("rstw_gated_ram_we", 32'(ram_we), 32'd0);
    tick();
    check("rstw_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rstw_busy",    32'(busy),    32'd0);
    reset = 0;
    tick();
    check("rstw_idle_busy", 32'(busy),       32'd0);
    check("rstw_cpu_ack2",  32'(cpu_ack),    32'd0);
    check("rstw_mem_40",    32'(mem[8'h40]), 32'h00);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    tick(); tick();
    check("rstw_rd_cpu_ack",   32'(cpu_ack),   32'd1);
    check("rstw_rd_cpu_rdata", 32'(cpu_rdata), 32'h00);
    cpu_req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
